// File: rtl/uart_rx_frame_pkg.sv
// Package for the UART receive slice.
// Holds the receiver state encoding (3-bit) and the default baud/frame/parity
// constants, which the command controller also uses.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } rx_state_e;

  // 50 MHz / 115200 baud
  localparam int unsigned BR_DEFAULT     = 434;
  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam bit          PAR_EVEN       = 1'b0;
  localparam bit          PAR_ODD_SEL    = 1'b1;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle between the serial line and the controller's read path.
//   rx, rx_en                            : line and enable into the receiver
//   data_out, data_vld, par_err, frm_err : received byte and its flags
//   busy                                 : receiver is inside a frame
// master = line driver / consumer side, slave = the receiver.
interface uart_rx_frame_if
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);
  logic              rx;
  logic              rx_en;
  logic [DATA_W-1:0] data_out;
  logic              data_vld;
  logic              par_err;
  logic              frm_err;
  logic              busy;

  modport master (
    output rx, rx_en,
    input  data_out, data_vld, par_err, frm_err, busy
  );

  modport slave (
    input  rx, rx_en,
    output data_out, data_vld, par_err, frm_err, busy
  );
endinterface

// File: rtl/uart_rx_frame_baud_tick.sv
// Bit-period counter. Counts 0..BR-1 and wraps; clr forces it back to 0.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear
//   mid        : count == BR/2-1
//   last       : count == BR-1
module uart_rx_frame_baud_tick
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned BR = BR_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic mid,
  output logic last
);
  localparam int unsigned CW = (BR > 1) ? $clog2(BR) : 1;

  logic [CW-1:0] bcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (clr || last) begin
      bcnt <= '0;
    end else begin
      bcnt <= bcnt + CW'(1);
    end
  end

  assign mid  = (bcnt == CW'(BR / 2 - 1));
  assign last = (bcnt == CW'(BR - 1));
endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 1 start, DATA_W data bits LSB-first, 1 parity, 1 stop.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of uart_rx_frame_if (rx, rx_en in; data_out,
//                data_vld, par_err, frm_err, busy out)
// data_vld is a one-cycle pulse; data_out and the error flags hold until the
// next pulse. A stop bit sampled low parks the receiver in BRK until the
// line returns high.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned BR      = BR_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter bit          PAR_ODD = PAR_EVEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_frame_if.slave       bus
);
  localparam int unsigned IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  rx_state_e         state;
  logic              rx_m, rx_s, rx_d;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              perr;
  logic              bclr, mid, last;

  // Sync flops come out of reset high so release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Counter is realigned at the start-bit mid point; from there every bit
  // centre lands on 'last', and the natural wrap serves as the clear on the
  // DATA/PARITY/STOP entries. IDLE and BRK simply hold it at zero.
  assign bclr = (state == IDLE) || (state == BRK) || ((state == START) && mid);

  uart_rx_frame_baud_tick #(
    .BR (BR)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bclr),
    .mid   (mid),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      shreg        <= '0;
      perr         <= 1'b0;
      bus.data_out <= '0;
      bus.data_vld <= 1'b0;
      bus.par_err  <= 1'b0;
      bus.frm_err  <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.data_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_en && rx_d && !rx_s) begin
            state    <= START;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (mid) begin
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        DATA: begin
          if (last) begin
            // Right shift: after DATA_W samples the first bit sits at bit 0.
            shreg <= {rx_s, shreg[DATA_W-1:1]};
            idx   <= idx + IW'(1);
            if (idx == LAST_IDX) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (last) begin
            perr  <= (rx_s != (^shreg ^ PAR_ODD));
            state <= STOP;
          end
        end
        STOP: begin
          if (last) begin
            bus.data_vld <= 1'b1;
            bus.data_out <= shreg;
            bus.par_err  <= perr;
            bus.frm_err  <= ~rx_s;
            if (rx_s) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              state <= BRK;
            end
          end
        end
        BRK: begin
          if (rx_s) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
